// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - instruction fetch, next-PC resolution, jal link and fault trap.
// Optional FETCH_HALT_ON_ZERO_EN: an all-zero instruction halts the unit in DONE.
module fetch_pc_unit #(
  parameter int DEPTH    = 1024,
  parameter int XLEN     = 32,
  parameter int RESET_PC = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DEPTH*32-1:0]      instruction_stream,
  input  logic                     stall,
  input  logic [XLEN-1:0]          rs_val,
  input  logic [XLEN-1:0]          rt_val,
  output logic [31:0]              instr,
  output logic [$clog2(DEPTH)-1:0] pc,
  output logic                     valid,
  output logic                     link_we,
  output logic [4:0]               link_addr,
  output logic [XLEN-1:0]          link_data,
  output logic                     branch_taken,
  output logic                     halted,
  output logic                     fault,
  output logic [31:0]              retire_cnt
);
  localparam int PW = $clog2(DEPTH);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BGT     = 6'b000110;
  localparam logic [5:0] FN_JR      = 6'b001000;

  typedef enum logic [1:0] {
    S_RUN,
    S_FAULT
`ifdef FETCH_HALT_ON_ZERO_EN
    , S_DONE
`endif
  } state_t;

  state_t state_q, state_d;

  logic [31:0] word;
  logic [5:0]  op, funct;
  logic [15:0] imm;
  logic [25:0] target;
  logic        is_branch, is_j, is_jal, is_jr, cond, taken;
  logic [32:0] pc_ext, imm_ext, rs_u, n;
  logic        oor, advance;

  assign word   = instruction_stream[{pc, 5'b00000} +: 32];
  assign op     = word[31:26];
  assign funct  = word[5:0];
  assign imm    = word[15:0];
  assign target = word[25:0];

  assign is_branch = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BGT);
  assign is_j      = (op == OP_J);
  assign is_jal    = (op == OP_JAL);
  assign is_jr     = (op == OP_SPECIAL) && (funct == FN_JR);

  always_comb begin
    cond = 1'b0;
    case (op)
      OP_BEQ:  cond = (rs_val == rt_val);
      OP_BNE:  cond = (rs_val != rt_val);
      OP_BGT:  cond = ($signed(rs_val) > $signed(rt_val));
      default: cond = 1'b0;
    endcase
  end

  assign taken   = (is_branch && cond) || is_j || is_jal || is_jr;
  assign pc_ext  = 33'(pc);
  assign imm_ext = {{17{imm[15]}}, imm};
  assign rs_u    = 33'(rs_val);

  // n is a signed 33-bit word index so that backward branches below 0 are detectable
  always_comb begin
    n = pc_ext + 33'd1;
    if (is_branch && cond)  n = pc_ext + imm_ext;
    else if (is_j || is_jal) n = {7'b0, target};
    else if (is_jr)         n = rs_u;
  end

  assign oor = n[32] || (n[31:0] >= 32'(DEPTH));

  assign valid     = !rst && (state_q == S_RUN);
  assign instr     = valid ? word : 32'h0;
  assign halted    = (state_q != S_RUN);
  assign fault     = (state_q == S_FAULT);
  assign link_addr = 5'd31;
  assign link_data = XLEN'(pc_ext + 33'd1);
  assign link_we   = is_jal && valid && !stall && !oor;

  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    if (state_q == S_RUN && valid && !stall) begin
`ifdef FETCH_HALT_ON_ZERO_EN
      if (word == 32'h0) begin
        state_d = S_DONE;
      end else if (oor) begin
        state_d = S_FAULT;
      end else begin
        advance = 1'b1;
      end
`else
      if (oor) begin
        state_d = S_FAULT;
      end else begin
        advance = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= PW'(RESET_PC);
      retire_cnt   <= 32'h0;
      branch_taken <= 1'b0;
    end else begin
      branch_taken <= advance && taken;
      if (advance) begin
        pc <= n[PW-1:0];
        if (retire_cnt != 32'hFFFF_FFFF) retire_cnt <= retire_cnt + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - table-driven check of fetch_pc_unit with DEPTH=16.
module tb_fetch_pc_unit;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [DEPTH*32-1:0] stream;
  logic              stall;
  logic [31:0]       rs_val, rt_val;
  logic [31:0]       instr;
  logic [3:0]        pc;
  logic              valid, link_we, branch_taken, halted, fault;
  logic [4:0]        link_addr;
  logic [31:0]       link_data, retire_cnt;

  fetch_pc_unit #(.DEPTH(DEPTH), .XLEN(32), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .instruction_stream(stream), .stall(stall),
    .rs_val(rs_val), .rt_val(rt_val), .instr(instr), .pc(pc), .valid(valid),
    .link_we(link_we), .link_addr(link_addr), .link_data(link_data),
    .branch_taken(branch_taken), .halted(halted), .fault(fault),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int stall; int rs; int rt;
    int pre_pc; int lwe;
    int post_pc; int bt; int ret;
  } vec_t;

  localparam logic [31:0] ADDI = 32'h2001_0001;

  logic [31:0] prog [DEPTH];
  vec_t vt [13];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_all_addi();
    for (int i = 0; i < DEPTH; i++) prog[i] = ADDI;
  endtask

  task automatic load_stream();
    for (int i = 0; i < DEPTH; i++) stream[32*i +: 32] = prog[i];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; rs_val = 32'h0; rt_val = 32'h0;
    load_all_addi();
    prog[3]  = 32'h1000_0002;  // beq +2
    prog[5]  = 32'h1400_0002;  // bne +2
    prog[7]  = 32'h1800_0002;  // bgt +2
    prog[9]  = 32'h1800_0002;  // bgt +2 (not taken)
    prog[10] = 32'h0C00_000E;  // jal 14
    prog[14] = 32'h0000_0008;  // jr
    load_stream();

    vt[0]  = '{0, 0, 0, 0, 0, 1, 0, 1};
    vt[1]  = '{0, 0, 0, 1, 0, 2, 0, 2};
    vt[2]  = '{0, 0, 0, 2, 0, 3, 0, 3};
    vt[3]  = '{1, 5, 5, 3, 0, 3, 0, 3};
    vt[4]  = '{1, 5, 5, 3, 0, 3, 0, 3};
    vt[5]  = '{1, 5, 5, 3, 0, 3, 0, 3};
    vt[6]  = '{0, 5, 5, 3, 0, 5, 1, 4};
    vt[7]  = '{0, 5, 2, 5, 0, 7, 1, 5};
    vt[8]  = '{0, 7, -1, 7, 0, 9, 1, 6};
    vt[9]  = '{0, -1, 7, 9, 0, 10, 0, 7};
    vt[10] = '{0, 0, 0, 10, 1, 14, 1, 8};
    vt[11] = '{0, 14, 0, 14, 0, 14, 1, 9};
    vt[12] = '{1, 14, 0, 14, 0, 14, 0, 9};

    @(posedge clk); #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_retire", retire_cnt, 32'd0);
    check("rst_bt", 32'(branch_taken), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("link_addr", 32'(link_addr), 32'd31);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      stall = vt[i].stall[0];
      rs_val = vt[i].rs;
      rt_val = vt[i].rt;
      @(negedge clk);
      check($sformatf("v%0d_pre_pc", i), 32'(pc), vt[i].pre_pc);
      check($sformatf("v%0d_valid", i), 32'(valid), 32'd1);
      check($sformatf("v%0d_instr", i), instr, prog[vt[i].pre_pc]);
      check($sformatf("v%0d_link_we", i), 32'(link_we), vt[i].lwe);
      check($sformatf("v%0d_link_data", i), link_data, vt[i].pre_pc + 1);
      @(posedge clk); #1;
      check($sformatf("v%0d_pc", i), 32'(pc), vt[i].post_pc);
      check($sformatf("v%0d_bt", i), 32'(branch_taken), vt[i].bt);
      check($sformatf("v%0d_retire", i), retire_cnt, vt[i].ret);
    end

    // sequential fall-through past the last word
    stall = 1'b0; rs_val = 32'h0; rt_val = 32'h0;
    load_all_addi(); load_stream();
    do_reset();
    repeat (15) @(posedge clk);
    #1;
    check("seq_pc15", 32'(pc), 32'd15);
    check("seq_ret15", retire_cnt, 32'd15);
    @(posedge clk); #1;
    check("seqf_fault", 32'(fault), 32'd1);
    check("seqf_halted", 32'(halted), 32'd1);
    check("seqf_valid", 32'(valid), 32'd0);
    check("seqf_instr", instr, 32'd0);
    check("seqf_pc", 32'(pc), 32'd15);
    check("seqf_ret", retire_cnt, 32'd15);
    @(posedge clk); #1;
    check("seqf_hold_pc", 32'(pc), 32'd15);
    check("seqf_hold_fault", 32'(fault), 32'd1);
    do_reset();
    check("clr_pc", 32'(pc), 32'd0);
    check("clr_fault", 32'(fault), 32'd0);
    check("clr_halted", 32'(halted), 32'd0);
    check("clr_ret", retire_cnt, 32'd0);

    // jr out of range
    prog[0] = 32'h0000_0008; load_stream();
    rs_val = 32'd16;
    do_reset();
    @(posedge clk); #1;
    check("jr_fault", 32'(fault), 32'd1);
    check("jr_pc", 32'(pc), 32'd0);
    check("jr_ret", retire_cnt, 32'd0);

    // backward branch below zero
    prog[0] = 32'h1000_FFFF; load_stream();
    rs_val = 32'd3; rt_val = 32'd3;
    do_reset();
    @(posedge clk); #1;
    check("beq_neg_fault", 32'(fault), 32'd1);
    check("beq_neg_bt", 32'(branch_taken), 32'd0);

    // faulting jal suppresses its link write
    prog[0] = 32'h0C00_0014; load_stream();
    do_reset();
    @(negedge clk);
    check("jal_oor_link_we", 32'(link_we), 32'd0);
    @(posedge clk); #1;
    check("jal_oor_fault", 32'(fault), 32'd1);

    // all-zero instruction at word 4
    load_all_addi(); prog[4] = 32'h0; load_stream();
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    check("zero_pc4", 32'(pc), 32'd4);
    check("zero_ret4", retire_cnt, 32'd4);
    @(posedge clk); #1;
`ifdef FETCH_HALT_ON_ZERO_EN
    check("zero_halted", 32'(halted), 32'd1);
    check("zero_fault", 32'(fault), 32'd0);
    check("zero_valid", 32'(valid), 32'd0);
    check("zero_pc", 32'(pc), 32'd4);
    check("zero_ret", retire_cnt, 32'd4);
`else
    check("zero_halted", 32'(halted), 32'd0);
    check("zero_pc", 32'(pc), 32'd5);
    check("zero_ret", retire_cnt, 32'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
